// File: rtl/irq_ctrl_if.sv
// Register bus between the Bridge and the interrupt controller.
// There is no handshake: WE is a one-cycle write strobe, and every write completes on the edge where WE is high. Dout is combinational from Addr, so there is no backpressure or wait state.
interface irq_ctrl_if;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, output WE, output Din, input Dout);
  modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: latches and masks device requests, presents one winner on HWInt,
// and sequences the claim / EOI handshake. A watchdog recovers from a handler that never writes EOI.
module irq_ctrl #(
  parameter int N_SRC    = 6,
  parameter int WDOG_CYC = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  irq_ctrl_if.slave        bus,
  output logic [N_SRC-1:0] HWInt
);

  localparam int            CW       = $clog2(WDOG_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(WDOG_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] insvc_q, insvc_d;
  logic [2:0]       cur_id_q, cur_id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wdog_q, wdog_d;

  logic [2:0]       off;
  logic             wr_pend, wr_mask, wr_mode, wr_claim, wr_eoi, wr_stat;
  logic [N_SRC-1:0] elig, cur_vec, edge_set, edge_clr;
  logic [2:0]       win_id;
  logic             win_vld;
  logic             claim_ok;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign off      = bus.Addr[4:2];
  assign wr_pend  = bus.WE && (off == 3'd0);
  assign wr_mask  = bus.WE && (off == 3'd1);
  assign wr_mode  = bus.WE && (off == 3'd2);
  assign wr_claim = bus.WE && (off == 3'd3);
  assign wr_eoi   = bus.WE && (off == 3'd4);
  assign wr_stat  = bus.WE && (off == 3'd5);

  // Only some address and data bits are decoded; the others are folded into one signal so that lint does not report them as unused.
  assign unused_bits = ^{bus.Addr, bus.Din};

  assign elig    = pend_q & mask_q & ~insvc_q;
  assign cur_vec = N_SRC'(1) << cur_id_q;

  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_id  = 3'(i);
        win_vld = 1'b1;
      end
    end
  end

  assign claim_ok = (state_q == S_ASSERT) && wr_claim && (bus.Din[2:0] == cur_id_q);

  // Edge-mode bits are sticky until W1C or claim, and a new edge beats a clear on the same cycle.
  // Level-mode bits simply track the line.
  assign edge_set = irq_in & ~prev_q;
  assign edge_clr = (wr_pend ? bus.Din[N_SRC-1:0] : '0) | (claim_ok ? cur_vec : '0);
  assign pend_d   = (mode_q & (edge_set | (pend_q & ~edge_clr))) | (~mode_q & irq_in);
  assign mask_d   = wr_mask ? bus.Din[N_SRC-1:0] : mask_q;
  assign mode_d   = wr_mode ? bus.Din[N_SRC-1:0] : mode_q;

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    insvc_d  = insvc_q;
    cnt_d    = cnt_q;
    wdog_d   = wdog_q;
    if (wr_stat && bus.Din[8]) begin
      wdog_d = 1'b0;
    end
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d  = S_ASSERT;
          cur_id_d = win_id;
        end
      end
      S_ASSERT: begin
        if (claim_ok) begin
          state_d = S_SERVICE;
          insvc_d = insvc_q | cur_vec;
          cnt_d   = '0;
        end else if (!win_vld) begin
          state_d = S_IDLE;
        end else begin
          cur_id_d = win_id;
        end
      end
      S_SERVICE: begin
        if (wr_eoi) begin
          state_d = S_IDLE;
          insvc_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          insvc_d = '0;
          wdog_d  = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      mask_q   <= '0;
      mode_q   <= '0;
      prev_q   <= '0;
      insvc_q  <= '0;
      cur_id_q <= '0;
      cnt_q    <= '0;
      wdog_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      prev_q   <= irq_in;
      insvc_q  <= insvc_d;
      cur_id_q <= cur_id_d;
      cnt_q    <= cnt_d;
      wdog_q   <= wdog_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      3'd0:    rdata = 32'(pend_q);
      3'd1:    rdata = 32'(mask_q);
      3'd2:    rdata = 32'(mode_q);
      3'd3:    rdata = {(state_q == S_ASSERT), 28'b0, cur_id_q};
      3'd5:    rdata = {23'b0, wdog_q, 6'b0, state_q};
      default: rdata = '0;
    endcase
  end

  assign bus.Dout = rdata;
  assign HWInt    = (state_q == S_ASSERT) ? cur_vec : '0;

endmodule
